// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the multi-cycle control FSM and the datapath.
// master: the control FSM (reads instruction fields and flags, drives controls).
// slave:  the datapath (drives instruction fields and flags, reads controls).
interface multicycle_ctrl_fsm_if;
  logic [6:0] op;
  logic [2:0] fun3;
  logic       fun7;
  logic       zeroflag;
  logic       signflag;
  logic       mem_ready;

  logic       PCwrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRwrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUsrcA;
  logic [1:0] ALUsrcB;
  logic [2:0] ALUcontrol;
  logic [1:0] ImmSrc;
  logic       instret;
  logic       halted;

  modport master (
    input  op, fun3, fun7, zeroflag, signflag, mem_ready,
    output PCwrite, AdrSrc, MemWrite, IRwrite, RegWrite, ResultSrc,
           ALUsrcA, ALUsrcB, ALUcontrol, ImmSrc, instret, halted
  );

  modport slave (
    output op, fun3, fun7, zeroflag, signflag, mem_ready,
    input  PCwrite, AdrSrc, MemWrite, IRwrite, RegWrite, ResultSrc,
           ALUsrcA, ALUsrcB, ALUcontrol, ImmSrc, instret, halted
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for a multi-cycle RV32-subset core sharing one ALU and
// one unified memory. Sequences FETCH..WRITEBACK, decodes ALU operation and
// immediate format, resolves branches from ALU flags and stalls on mem_ready.
module multicycle_ctrl_fsm #(
  parameter bit USE_MEM_READY = 1'b1,
  parameter bit ILLEGAL_HALT  = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  multicycle_ctrl_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BRNCH = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  state_t     state_q, state_d;
  logic       rdy;
  logic       pcw, adr, memw, irw, regw, iret, hlt;
  logic [1:0] res_src, src_a, src_b, imm_src;
  logic [2:0] alu_ctl;

  // ALU operation for R/I arithmetic; sub only for R-type with fun7 set
  function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  alu_dec = sub ? 3'b010 : 3'b000;
      3'b001:  alu_dec = 3'b001;
      3'b100:  alu_dec = 3'b100;
      3'b101:  alu_dec = 3'b101;
      3'b110:  alu_dec = 3'b110;
      3'b111:  alu_dec = 3'b111;
      default: alu_dec = 3'b000;
    endcase
  endfunction

  assign rdy = USE_MEM_READY ? bus.mem_ready : 1'b1;

  // Next-state sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (rdy) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRNCH:          state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (rdy) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (rdy) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  // State register; reset lands in FETCH immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Per-state control decode; enables are forced low while rst is held so a
  // mid-instruction reset cannot leak a write
  always_comb begin
    pcw     = 1'b0;
    adr     = 1'b0;
    memw    = 1'b0;
    irw     = 1'b0;
    regw    = 1'b0;
    iret    = 1'b0;
    hlt     = 1'b0;
    res_src = 2'b10;
    src_a   = 2'b00;
    src_b   = 2'b10;
    alu_ctl = 3'b000;
    case (state_q)
      S_FETCH: begin
        irw = rdy;
        pcw = rdy;
      end
      S_DECODE: begin
        src_a = 2'b01;
        src_b = 2'b01;
      end
      S_MEMADR: begin
        src_a = 2'b10;
        src_b = 2'b01;
      end
      S_MEMREAD: begin
        adr     = 1'b1;
        res_src = 2'b00;
      end
      S_MEMWB: begin
        res_src = 2'b01;
        regw    = 1'b1;
        iret    = 1'b1;
      end
      S_MEMWRITE: begin
        adr     = 1'b1;
        res_src = 2'b00;
        memw    = 1'b1;
        iret    = rdy;
      end
      S_EXECR: begin
        src_a   = 2'b10;
        src_b   = 2'b00;
        alu_ctl = alu_dec(bus.fun3, bus.op[5] & bus.fun7);
      end
      S_EXECI: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        alu_ctl = alu_dec(bus.fun3, bus.op[5] & bus.fun7);
      end
      S_ALUWB: begin
        res_src = 2'b00;
        regw    = 1'b1;
        iret    = 1'b1;
      end
      S_BRANCH: begin
        src_a   = 2'b10;
        src_b   = 2'b00;
        alu_ctl = 3'b010;
        res_src = 2'b00;
        iret    = 1'b1;
        case (bus.fun3)
          3'b000:  pcw = bus.zeroflag;
          3'b001:  pcw = ~bus.zeroflag;
          3'b100:  pcw = bus.signflag;
          default: pcw = 1'b0;
        endcase
      end
      S_JAL: begin
        src_a   = 2'b01;
        src_b   = 2'b10;
        res_src = 2'b00;
        pcw     = 1'b1;
      end
      S_HALT:  hlt = 1'b1;
      default: ;
    endcase
    if (rst) begin
      pcw  = 1'b0;
      memw = 1'b0;
      irw  = 1'b0;
      regw = 1'b0;
      iret = 1'b0;
      hlt  = 1'b0;
    end
  end

  // Immediate format follows the opcode regardless of state
  always_comb begin
    case (bus.op)
      OP_LOAD, OP_ITYPE: imm_src = 2'b00;
      OP_STORE:          imm_src = 2'b01;
      OP_BRNCH:          imm_src = 2'b10;
      OP_JAL:            imm_src = 2'b11;
      default:           imm_src = 2'b00;
    endcase
  end

  assign bus.PCwrite    = pcw;
  assign bus.AdrSrc     = adr;
  assign bus.MemWrite   = memw;
  assign bus.IRwrite    = irw;
  assign bus.RegWrite   = regw;
  assign bus.ResultSrc  = res_src;
  assign bus.ALUsrcA    = src_a;
  assign bus.ALUsrcB    = src_b;
  assign bus.ALUcontrol = alu_ctl;
  assign bus.ImmSrc     = imm_src;
  assign bus.instret    = iret;
  assign bus.halted     = hlt;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: per-cycle vector table with a scoreboard
// of expected control words, plus an asynchronous reset corner sequence.
module tb_multicycle_ctrl_fsm;
  logic clk;
  logic rst;

  multicycle_ctrl_fsm_if bus ();

  multicycle_ctrl_fsm #(.USE_MEM_READY(1'b1), .ILLEGAL_HALT(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {T_F, T_D, T_MA, T_MR, T_MWB, T_MW, T_ER, T_EI, T_WB, T_BR, T_J, T_H} tst_t;

  typedef struct packed {
    logic       pcw, adr, memw, irw, regw;
    logic [1:0] rs, a, b;
    logic [2:0] alu;
    logic [1:0] imm;
    logic       ir, hl;
  } outs_t;

  typedef struct {
    outs_t v;
    outs_t m;
    string nm;
  } sbe_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7, zf, sf, mr, do_rst;
    tst_t       st;
    string      nm;
  } vec_t;

  int    checks = 0;
  int    failures = 0;
  sbe_t  sb[$];
  vec_t  tbl[$];
  outs_t act;

  always_comb act = {bus.PCwrite, bus.AdrSrc, bus.MemWrite, bus.IRwrite, bus.RegWrite,
                     bus.ResultSrc, bus.ALUsrcA, bus.ALUsrcB, bus.ALUcontrol, bus.ImmSrc,
                     bus.instret, bus.halted};

  // Expected control word for a given state and inputs, straight from the
  // control table; unspecified selects are left as don't-care
  function automatic sbe_t model(tst_t s, logic [6:0] op, logic [2:0] f3, logic f7,
                                 logic zf, logic sf, logic mr, string nm);
    sbe_t e;
    e.nm = nm;
    e.v = '0;
    e.m = '0;
    e.m.pcw = 1'b1; e.m.memw = 1'b1; e.m.irw = 1'b1; e.m.regw = 1'b1;
    e.m.ir = 1'b1; e.m.hl = 1'b1; e.m.imm = 2'b11;
    case (op)
      7'b0100011: e.v.imm = 2'b01;
      7'b1100011: e.v.imm = 2'b10;
      7'b1101111: e.v.imm = 2'b11;
      default:    e.v.imm = 2'b00;
    endcase
    case (s)
      T_F: begin
        e.m.adr = 1'b1; e.m.a = 2'b11; e.m.b = 2'b11; e.m.alu = 3'b111; e.m.rs = 2'b11;
        e.v.b = 2'b10; e.v.rs = 2'b10; e.v.irw = mr; e.v.pcw = mr;
      end
      T_D: begin
        e.m.a = 2'b11; e.m.b = 2'b11; e.m.alu = 3'b111;
        e.v.a = 2'b01; e.v.b = 2'b01;
      end
      T_MA: begin
        e.m.a = 2'b11; e.m.b = 2'b11; e.m.alu = 3'b111;
        e.v.a = 2'b10; e.v.b = 2'b01;
      end
      T_MR: begin
        e.m.adr = 1'b1; e.m.rs = 2'b11; e.v.adr = 1'b1;
      end
      T_MWB: begin
        e.m.rs = 2'b11; e.v.rs = 2'b01; e.v.regw = 1'b1; e.v.ir = 1'b1;
      end
      T_MW: begin
        e.m.adr = 1'b1; e.m.rs = 2'b11;
        e.v.adr = 1'b1; e.v.memw = 1'b1; e.v.ir = mr;
      end
      T_ER, T_EI: begin
        e.m.a = 2'b11; e.m.b = 2'b11; e.m.alu = 3'b111;
        e.v.a = 2'b10; e.v.b = (s == T_EI) ? 2'b01 : 2'b00;
        case (f3)
          3'b000:  e.v.alu = (op[5] && f7) ? 3'b010 : 3'b000;
          3'b001:  e.v.alu = 3'b001;
          3'b100:  e.v.alu = 3'b100;
          3'b101:  e.v.alu = 3'b101;
          3'b110:  e.v.alu = 3'b110;
          3'b111:  e.v.alu = 3'b111;
          default: e.v.alu = 3'b000;
        endcase
      end
      T_WB: begin
        e.m.rs = 2'b11; e.v.regw = 1'b1; e.v.ir = 1'b1;
      end
      T_BR: begin
        e.m.a = 2'b11; e.m.b = 2'b11; e.m.alu = 3'b111; e.m.rs = 2'b11;
        e.v.a = 2'b10; e.v.alu = 3'b010; e.v.ir = 1'b1;
        if (f3 == 3'b000)      e.v.pcw = zf;
        else if (f3 == 3'b001) e.v.pcw = ~zf;
        else if (f3 == 3'b100) e.v.pcw = sf;
        else                   e.v.pcw = 1'b0;
      end
      T_J: begin
        e.m.a = 2'b11; e.m.b = 2'b11; e.m.alu = 3'b111; e.m.rs = 2'b11;
        e.v.a = 2'b01; e.v.b = 2'b10; e.v.pcw = 1'b1;
      end
      T_H: e.v.hl = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  task automatic check(input sbe_t e);
    checks++;
    if (((act ^ e.v) & e.m) != '0) begin
      failures++;
      $display("FAIL %s: got=%h required=%h care=%h", e.nm, act, e.v, e.m);
    end
  endtask

  // Scoreboard consumer: compares mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (sb.size() != 0) check(sb.pop_front());
  end

  task automatic add(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                     input logic zf, input logic sf, input logic mr, input tst_t st,
                     input string nm);
    vec_t r;
    r.op = op; r.f3 = f3; r.f7 = f7; r.zf = zf; r.sf = sf; r.mr = mr;
    r.st = st; r.nm = nm; r.do_rst = 1'b0;
    tbl.push_back(r);
  endtask

  task automatic add_rst(input logic [6:0] op, input string nm);
    add(op, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, T_F, nm);
    tbl[tbl.size()-1].do_rst = 1'b1;
  endtask

  // Drive one cycle of inputs (just after posedge) and queue its expectation
  task automatic run(input vec_t r);
    rst            = r.do_rst;
    bus.op         = r.op;
    bus.fun3       = r.f3;
    bus.fun7       = r.f7;
    bus.zeroflag   = r.zf;
    bus.signflag   = r.sf;
    bus.mem_ready  = r.mr;
    // while rst is held the enables must be low, i.e. FETCH with no ready
    sb.push_back(model(r.st, r.op, r.f3, r.f7, r.zf, r.sf, r.do_rst ? 1'b0 : r.mr, r.nm));
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    sbe_t e;

    // reset with mem_ready high: enables must stay low
    add_rst(LW, "reset0");
    add_rst(LW, "reset1");
    // lw, no stalls: F D MA MR MWB
    add(LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, T_F,   "lw_F");
    add(LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, T_D,   "lw_D");
    add(LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, T_MA,  "lw_MA");
    add(LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, T_MR,  "lw_MR");
    add(LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, T_MWB, "lw_MWB");
    // sw with three not-ready cycles in MEMWRITE
    add(SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, T_F,  "sw_F");
    add(SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, T_D,  "sw_D");
    add(SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, T_MA, "sw_MA");
    add(SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, T_MW, "sw_MW_wait1");
    add(SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, T_MW, "sw_MW_wait2");
    add(SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, T_MW, "sw_MW_wait3");
    add(SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, T_MW, "sw_MW_done");
    // R-type sub
    add(RT, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, T_F,  "sub_F");
    add(RT, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, T_D,  "sub_D");
    add(RT, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, T_ER, "sub_ER");
    add(RT, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, T_WB, "sub_WB");
    // I-type addi with fun7 bit set must still add
    add(IT, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, T_F,  "addi_F");
    add(IT, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, T_D,  "addi_D");
    add(IT, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, T_EI, "addi_EI");
    add(IT, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, T_WB, "addi_WB");
    // R-type xor and I-type srl
    add(RT, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1, T_F,  "xor_F");
    add(RT, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1, T_D,  "xor_D");
    add(RT, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1, T_ER, "xor_ER");
    add(RT, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1, T_WB, "xor_WB");
    add(IT, 3'b101, 1'b0, 1'b0, 1'b0, 1'b1, T_F,  "srli_F");
    add(IT, 3'b101, 1'b0, 1'b0, 1'b0, 1'b1, T_D,  "srli_D");
    add(IT, 3'b101, 1'b0, 1'b0, 1'b0, 1'b1, T_EI, "srli_EI");
    add(IT, 3'b101, 1'b0, 1'b0, 1'b0, 1'b1, T_WB, "srli_WB");
    // branches
    add(BR, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, T_F,  "beq_F");
    add(BR, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, T_D,  "beq_D");
    add(BR, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, T_BR, "beq_taken");
    add(BR, 3'b001, 1'b0, 1'b1, 1'b0, 1'b1, T_F,  "bne_F");
    add(BR, 3'b001, 1'b0, 1'b1, 1'b0, 1'b1, T_D,  "bne_D");
    add(BR, 3'b001, 1'b0, 1'b1, 1'b0, 1'b1, T_BR, "bne_not_taken");
    add(BR, 3'b100, 1'b0, 1'b0, 1'b1, 1'b1, T_F,  "blt_F");
    add(BR, 3'b100, 1'b0, 1'b0, 1'b1, 1'b1, T_D,  "blt_D");
    add(BR, 3'b100, 1'b0, 1'b0, 1'b1, 1'b1, T_BR, "blt_taken");
    add(BR, 3'b111, 1'b0, 1'b1, 1'b1, 1'b1, T_F,  "b111_F");
    add(BR, 3'b111, 1'b0, 1'b1, 1'b1, 1'b1, T_D,  "b111_D");
    add(BR, 3'b111, 1'b0, 1'b1, 1'b1, 1'b1, T_BR, "b111_never");
    // jal
    add(JL, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, T_F,  "jal_F");
    add(JL, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, T_D,  "jal_D");
    add(JL, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, T_J,  "jal_J");
    add(JL, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, T_WB, "jal_WB");
    // lw with a fetch stall and a read stall
    add(LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, T_F,   "lws_F_wait");
    add(LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, T_F,   "lws_F");
    add(LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, T_D,   "lws_D");
    add(LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, T_MA,  "lws_MA");
    add(LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, T_MR,  "lws_MR_wait");
    add(LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, T_MR,  "lws_MR");
    add(LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, T_MWB, "lws_MWB");
    // illegal opcode halts until reset
    add(BAD, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, T_F, "ill_F");
    add(BAD, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, T_D, "ill_D");
    for (int i = 0; i < 12; i++)
      add(BAD, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, T_H, $sformatf("halt_%0d", i));
    add_rst(BAD, "halt_reset");
    add(LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, T_F,   "post_halt_F");
    add(LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, T_D,   "post_halt_D");
    add(LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, T_MA,  "post_halt_MA");
    add(LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, T_MR,  "post_halt_MR");
    add(LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, T_MWB, "post_halt_MWB");

    rst           = 1'b1;
    bus.op        = LW;
    bus.fun3      = 3'b000;
    bus.fun7      = 1'b0;
    bus.zeroflag  = 1'b0;
    bus.signflag  = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) run(tbl[i]);

    // sw stalled in MEMWRITE, then reset asserted mid-cycle
    add(SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, T_F,  "ar_F");
    add(SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, T_D,  "ar_D");
    add(SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, T_MA, "ar_MA");
    add(SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, T_MW, "ar_MW_wait");
    for (int i = tbl.size() - 4; i < tbl.size(); i++) run(tbl[i]);
    bus.mem_ready = 1'b0;
    sb.push_back(model(T_MW, SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, "ar_MW_before_rst"));
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check(model(T_F, SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, "ar_async_drop"));
    @(posedge clk);
    #1;
    rst = 1'b0;
    v.op = SW; v.f3 = 3'b010; v.f7 = 1'b0; v.zf = 1'b0; v.sf = 1'b0; v.do_rst = 1'b0;
    v.mr = 1'b1; v.st = T_F;  v.nm = "ar_restart_F";  run(v);
    v.st = T_D;  v.nm = "ar_restart_D";  run(v);
    v.st = T_MA; v.nm = "ar_restart_MA"; run(v);
    v.st = T_MW; v.nm = "ar_restart_MW"; run(v);

    e = model(T_F, SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, "final_F");
    sb.push_back(e);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
